// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sample generator:
// FSM state encoding, LFSR geometry and the fill-beat count helper.
package constraint_sampler_pkg;

    localparam int LFSR_W = 64;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT,
        EVAL,
        EMIT
    } state_e;

    // Number of LFSR words needed to cover one candidate vector.
    function automatic int calc_nb(input int vec_w);
        return (vec_w + LFSR_W - 1) / LFSR_W;
    endfunction

endpackage

// File: rtl/constraint_sample_gen_if.sv
// Accepted-sample stream: valid/ready handshake carrying one candidate vector.
interface constraint_sample_gen_if #(
    parameter int VEC_W = 551
);
    logic             valid;
    logic             ready;
    logic [VEC_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr64_galois.sv
// 64-bit right-shifting Galois LFSR, x^64+x^63+x^61+x^60+1.
// A zero seed is replaced by 1 so the register never locks up.
module lfsr64_galois
    import constraint_sampler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q, q_d;

    always_comb begin
        // NOTE: default first, so every path assigns q_d and no latch is inferred.
        q_d = q_q;
        if (load) begin
            q_d = (seed == '0) ? LFSR_W'(1) : seed;
        end else if (step) begin
            q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : '0);
        end
    end

    // NOTE: non-blocking assignments only in clocked blocks, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_W'(1);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/constraint_sample_gen.sv
// Drives a combinational constraint checker with LFSR-built candidates and
// streams the accepted ones out, bounded by a per-sample attempt budget.
module constraint_sample_gen
    import constraint_sampler_pkg::*;
#(
    parameter int VEC_W     = 551,
    parameter int CHK_LAT   = 0,
    parameter int MAX_TRIES = 65536
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [15:0]              num_samples_i,
    input  logic                     seed_load_i,
    input  logic [LFSR_W-1:0]        seed_i,
    output logic [VEC_W-1:0]         cand_o,
    input  logic                     sat_i,
    constraint_sample_gen_if.master  smp,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [31:0]              attempts_o,
    output logic [15:0]              accepted_o
);

    localparam int NB     = calc_nb(VEC_W);
    localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int LAT_W  = 3;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [15:0]       target_q, target_d;
    logic [31:0]       tries_q, tries_d;
    logic [31:0]       attempts_q, attempts_d;
    logic [15:0]       accepted_q, accepted_d;
    logic [VEC_W-1:0]  cand_q, cand_d;
    logic [VEC_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              fail_q, fail_d;
    logic [VEC_W-1:0]  cand_shift;
    logic              lfsr_step, lfsr_load;
    logic [LFSR_W-1:0] lfsr_q;

    lfsr64_galois u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (lfsr_step),
        .load  (lfsr_load),
        .seed  (seed_i),
        .q     (lfsr_q)
    );

    // Each fill beat shifts the current LFSR word in at the LSB end.
    generate
        if (VEC_W > LFSR_W) begin : g_wide
            assign cand_shift = {cand_q[VEC_W-LFSR_W-1:0], lfsr_q};
        end else begin : g_narrow
            assign cand_shift = lfsr_q[VEC_W-1:0];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        target_d   = target_q;
        tries_d    = tries_q;
        attempts_d = attempts_q;
        accepted_d = accepted_q;
        cand_d     = cand_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        fail_d     = fail_q;
        lfsr_step  = 1'b0;
        lfsr_load  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Seed load lands on the same edge as start, so the fill sees the new seed.
                lfsr_load = seed_load_i;
                if (start_i) begin
                    target_d   = num_samples_i;
                    attempts_d = '0;
                    accepted_d = '0;
                    fail_d     = 1'b0;
                    tries_d    = '0;
                    beat_d     = '0;
                    if (num_samples_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                lfsr_step = 1'b1;
                cand_d    = cand_shift;
                beat_d    = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(NB - 1)) begin
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = (CHK_LAT == 0) ? EVAL : WAIT;
                end
            end
            WAIT: begin
                lat_d = lat_q + LAT_W'(1);
                if (lat_q == LAT_W'(CHK_LAT - 1)) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (attempts_q != '1) begin
                    attempts_d = attempts_q + 32'd1;
                end
                tries_d = tries_q + 32'd1;
                if (sat_i) begin
                    data_d  = cand_q;
                    valid_d = 1'b1;
                    tries_d = '0;
                    state_d = EMIT;
                end else if (tries_d == 32'(MAX_TRIES)) begin
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            EMIT: begin
                if (smp.ready) begin
                    valid_d    = 1'b0;
                    accepted_d = accepted_q + 16'd1;
                    if (accepted_d == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            lat_q      <= '0;
            target_q   <= '0;
            tries_q    <= '0;
            attempts_q <= '0;
            accepted_q <= '0;
            cand_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            target_q   <= target_d;
            tries_q    <= tries_d;
            attempts_q <= attempts_d;
            accepted_q <= accepted_d;
            cand_q     <= cand_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
        end
    end

    assign cand_o     = cand_q;
    assign smp.valid  = valid_q;
    assign smp.data   = data_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign fail_o     = fail_q;
    assign attempts_o = attempts_q;
    assign accepted_o = accepted_q;

endmodule

// File: tb/tb_constraint_sample_gen.sv
// Bench for constraint_sample_gen: one instance with no checker latency and a
// small attempt budget, one with a two-stage checker pipe.
module tb_constraint_sample_gen;

    localparam int VEC_W   = 551;
    localparam int NB      = (VEC_W + 63) / 64;
    localparam int TRIES_A = 8;
    localparam int TRIES_B = 65536;
    localparam logic [63:0] POLY_TAPS = 64'hD800_0000_0000_0000;
    localparam logic [63:0] SEED_B    = 64'hACE1_2345_6789_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic             a_start = 1'b0, a_seed_load = 1'b0;
    logic [15:0]      a_num = '0;
    logic [63:0]      a_seed = '0;
    logic [VEC_W-1:0] a_cand;
    logic             a_sat, a_busy, a_done, a_fail;
    logic [31:0]      a_att;
    logic [15:0]      a_acc;
    int               mode_a = 0;

    logic             b_start = 1'b0, b_seed_load = 1'b0;
    logic [15:0]      b_num = '0;
    logic [63:0]      b_seed = '0;
    logic [VEC_W-1:0] b_cand;
    logic             b_sat, b_busy, b_done, b_fail;
    logic [31:0]      b_att;
    logic [15:0]      b_acc;
    logic             b_p1 = 1'b0, b_p2 = 1'b0;

    constraint_sample_gen_if #(.VEC_W(VEC_W)) if_a ();
    constraint_sample_gen_if #(.VEC_W(VEC_W)) if_b ();

    constraint_sample_gen #(.VEC_W(VEC_W), .CHK_LAT(0), .MAX_TRIES(TRIES_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .num_samples_i(a_num),
        .seed_load_i(a_seed_load), .seed_i(a_seed), .cand_o(a_cand), .sat_i(a_sat),
        .smp(if_a), .busy_o(a_busy), .done_o(a_done), .fail_o(a_fail),
        .attempts_o(a_att), .accepted_o(a_acc)
    );

    constraint_sample_gen #(.VEC_W(VEC_W), .CHK_LAT(2), .MAX_TRIES(TRIES_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .num_samples_i(b_num),
        .seed_load_i(b_seed_load), .seed_i(b_seed), .cand_o(b_cand), .sat_i(b_sat),
        .smp(if_b), .busy_o(b_busy), .done_o(b_done), .fail_o(b_fail),
        .attempts_o(b_att), .accepted_o(b_acc)
    );

    // Checker stubs: 0 always accept, 1 reject the first three attempts,
    // 2 always reject, 3 a parity predicate on the candidate bits.
    function automatic logic sat_fn(input int mode, input int att, input logic [VEC_W-1:0] c);
        case (mode)
            0:       return 1'b1;
            1:       return (att >= 3);
            2:       return 1'b0;
            default: return c[0] ^ c[100] ^ c[VEC_W-1];
        endcase
    endfunction

    assign a_sat = sat_fn(mode_a, int'(a_att), a_cand);

    always @(posedge clk) begin
        b_p1 <= sat_fn(3, 0, b_cand);
        b_p2 <= b_p1;
    end
    assign b_sat = b_p2;

    // ---------------- reference model ----------------
    logic [63:0]      m_lfsr  [2];
    logic [VEC_W-1:0] m_cand  [2];
    logic [VEC_W-1:0] cur_exp [2];
    logic             cur_vld [2];
    logic             exp_fail[2];
    int               exp_att [2];
    int               exp_acc [2];
    int               m_acc   [2];
    int               done_cnt[2];
    int               hs_cnt  [2];
    logic             cmp_en  [2];
    logic [VEC_W-1:0] exp_qa[$];
    logic [VEC_W-1:0] exp_qb[$];

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ POLY_TAPS) : (s >> 1);
    endfunction

    // Plays a whole run forward: candidates are NB consecutive LFSR words,
    // oldest word most significant, truncated to VEC_W.
    task automatic predict(input int id, input int n, input int mode, input int max_tries);
        logic [63:0]         s;
        logic [NB*64-1:0]    w;
        logic [VEC_W-1:0]    c;
        int                  att, acc, tries;
        logic                fail;
        s = m_lfsr[id];
        att = 0; acc = 0; tries = 0; fail = 1'b0;
        if (id == 0) exp_qa.delete(); else exp_qb.delete();
        while (acc < n && !fail) begin
            for (int b = 0; b < NB; b++) begin
                w[(NB-1-b)*64 +: 64] = s;
                s = lfsr_next(s);
            end
            c = w[VEC_W-1:0];
            m_cand[id] = c;
            if (sat_fn(mode, att, c)) begin
                if (id == 0) exp_qa.push_back(c); else exp_qb.push_back(c);
                acc++;
                tries = 0;
            end else begin
                tries++;
                if (tries == max_tries) fail = 1'b1;
            end
            att++;
        end
        m_lfsr[id]   = s;
        exp_att[id]  = att;
        exp_acc[id]  = acc;
        exp_fail[id] = fail;
        m_acc[id]    = 0;
        cur_vld[id]  = 1'b0;
    endtask

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input int id, input logic valid, input logic ready,
                       input logic [VEC_W-1:0] data, input logic [VEC_W-1:0] cand,
                       input logic busy, input logic done, input logic fail,
                       input logic [31:0] att, input logic [15:0] acc);
        int pending;
        if (busy || done) check($sformatf("accepted_%0d", id), VEC_W'(acc), VEC_W'(m_acc[id]));
        if (valid) begin
            if (!cur_vld[id]) begin
                pending = (id == 0) ? exp_qa.size() : exp_qb.size();
                if (pending == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_sample_%0d: got a sample, expected none", id);
                    cur_exp[id] = data;
                end else begin
                    cur_exp[id] = (id == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
                end
                cur_vld[id] = 1'b1;
            end
            check($sformatf("sample_data_%0d", id), data, cur_exp[id]);
            check($sformatf("cand_hold_%0d", id), cand, cur_exp[id]);
            if (ready) begin
                m_acc[id]++;
                hs_cnt[id]++;
                cur_vld[id] = 1'b0;
            end
        end
        if (done) begin
            done_cnt[id]++;
            check($sformatf("done_attempts_%0d", id), VEC_W'(att), VEC_W'(exp_att[id]));
            check($sformatf("done_accepted_%0d", id), VEC_W'(acc), VEC_W'(exp_acc[id]));
            check($sformatf("done_fail_%0d", id), VEC_W'(fail), VEC_W'(exp_fail[id]));
            pending = (id == 0) ? exp_qa.size() : exp_qb.size();
            check($sformatf("done_leftover_%0d", id), VEC_W'(pending), VEC_W'(0));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en[0])
            cmp(0, if_a.valid, if_a.ready, if_a.data, a_cand, a_busy, a_done, a_fail, a_att, a_acc);
        if (rst_n && cmp_en[1])
            cmp(1, if_b.valid, if_b.ready, if_b.data, b_cand, b_busy, b_done, b_fail, b_att, b_acc);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int id, input int n, input int mode,
                             input logic seed_load, input logic [63:0] seed);
        if (seed_load) m_lfsr[id] = (seed == '0) ? 64'h1 : seed;
        if (id == 0) begin
            mode_a = mode;
            a_num = 16'(n); a_seed = seed; a_seed_load = seed_load; a_start = 1'b1;
            predict(0, n, mode, TRIES_A);
        end else begin
            b_num = 16'(n); b_seed = seed; b_seed_load = seed_load; b_start = 1'b1;
            predict(1, n, 3, TRIES_B);
        end
        tick();
        a_start = 1'b0; a_seed_load = 1'b0;
        b_start = 1'b0; b_seed_load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int d0;
        for (int i = 0; i < 2; i++) begin
            m_lfsr[i] = 64'h1; m_cand[i] = '0; cur_exp[i] = '0; cur_vld[i] = 1'b0;
            exp_fail[i] = 1'b0; exp_att[i] = 0; exp_acc[i] = 0; m_acc[i] = 0;
            done_cnt[i] = 0; hs_cnt[i] = 0; cmp_en[i] = 1'b0;
        end
        if_a.ready = 1'b0;
        if_b.ready = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_cand", a_cand, '0);
        check("rst_valid", VEC_W'(if_a.valid), '0);
        check("rst_data", if_a.data, '0);
        check("rst_busy", VEC_W'(a_busy), '0);
        check("rst_done", VEC_W'(a_done), '0);
        check("rst_fail", VEC_W'(a_fail), '0);
        check("rst_attempts", VEC_W'(a_att), '0);
        check("rst_accepted", VEC_W'(a_acc), '0);
        check("rst_b_valid", VEC_W'(if_b.valid), '0);
        check("rst_b_cand", b_cand, '0);
        rst_n = 1'b1;
        tick();
        cmp_en[0] = 1'b1;
        cmp_en[1] = 1'b1;

        // Seed 1, one sample, checker always satisfied
        if_a.ready = 1'b1;
        start_run(0, 1, 0, 1'b1, 64'h1);
        cyc = 1;
        while (!if_a.valid && cyc < 60) begin
            tick();
            cyc++;
            if (cyc == 2) check("first_fill_beat", VEC_W'(a_cand[63:0]), VEC_W'(64'h1));
        end
        check("valid_cycle", VEC_W'(cyc), VEC_W'(11));
        check("pin_word8", VEC_W'(if_a.data[63:0]), VEC_W'(64'h01B0_0000_0000_0000));
        check("pin_word7", VEC_W'(if_a.data[127:64]), VEC_W'(64'h0360_0000_0000_0000));
        check("pin_word0", VEC_W'(if_a.data[VEC_W-1:512]), VEC_W'(1));
        while (!a_done && cyc < 60) begin tick(); cyc++; end
        check("done_cycle_t1", VEC_W'(cyc), VEC_W'(12));
        repeat (3) tick();

        // Three rejections then accept; a start mid-run must be ignored
        d0 = done_cnt[0];
        start_run(0, 1, 1, 1'b0, '0);
        cyc = 1;
        while (!a_done && cyc < 300) begin
            a_start = (cyc == 15);
            if (cyc == 15) a_num = 16'd7;
            tick();
            cyc++;
        end
        a_start = 1'b0;
        check("done_cycle_t2", VEC_W'(cyc), VEC_W'(42));
        check("t2_attempts", VEC_W'(a_att), VEC_W'(4));
        check("t2_accepted", VEC_W'(a_acc), VEC_W'(1));
        check("t2_fail", VEC_W'(a_fail), VEC_W'(0));
        repeat (5) tick();
        check("t2_done_pulses", VEC_W'(done_cnt[0] - d0), VEC_W'(1));

        // Backpressure: 20 cycles with ready low in EMIT
        if_a.ready = 1'b0;
        start_run(0, 2, 0, 1'b0, '0);
        cyc = 1;
        while (!if_a.valid && cyc < 60) begin tick(); cyc++; end
        check("bp_valid", VEC_W'(if_a.valid), VEC_W'(1));
        repeat (20) tick();
        check("bp_accepted_hold", VEC_W'(a_acc), VEC_W'(0));
        check("bp_valid_hold", VEC_W'(if_a.valid), VEC_W'(1));
        if_a.ready = 1'b1;
        tick();
        if_a.ready = 1'b0;
        check("bp_accepted_hs", VEC_W'(a_acc), VEC_W'(1));
        check("bp_valid_drop", VEC_W'(if_a.valid), VEC_W'(0));
        if_a.ready = 1'b1;
        cyc = 0;
        while (!a_done && cyc < 60) begin tick(); cyc++; end
        check("bp_done", VEC_W'(a_acc), VEC_W'(2));
        repeat (3) tick();

        // Budget exhaustion after exactly 8 evaluations
        start_run(0, 1, 2, 1'b0, '0);
        cyc = 1;
        while (!a_done && cyc < 300) begin tick(); cyc++; end
        check("budget_done_cycle", VEC_W'(cyc), VEC_W'(81));
        check("budget_fail", VEC_W'(a_fail), VEC_W'(1));
        check("budget_attempts", VEC_W'(a_att), VEC_W'(8));
        tick();
        check("budget_busy", VEC_W'(a_busy), VEC_W'(0));
        check("budget_fail_sticky", VEC_W'(a_fail), VEC_W'(1));
        repeat (2) tick();

        // Zero samples: done next cycle, no fill, fail cleared
        start_run(0, 0, 0, 1'b0, '0);
        check("zero_done", VEC_W'(a_done), VEC_W'(1));
        check("zero_busy", VEC_W'(a_busy), VEC_W'(0));
        check("zero_fail_clr", VEC_W'(a_fail), VEC_W'(0));
        check("zero_attempts", VEC_W'(a_att), VEC_W'(0));
        check("zero_cand", a_cand, m_cand[0]);
        tick();
        check("zero_done_pulse", VEC_W'(a_done), VEC_W'(0));
        check("zero_no_fill", VEC_W'(a_busy), VEC_W'(0));
        tick();

        // Zero seed behaves as seed 1
        start_run(0, 1, 0, 1'b1, 64'h0);
        cyc = 1;
        while (!a_done && cyc < 60) begin tick(); cyc++; end
        check("seed0_word8", VEC_W'(if_a.data[63:0]), VEC_W'(64'h01B0_0000_0000_0000));
        check("seed0_word0", VEC_W'(if_a.data[VEC_W-1:512]), VEC_W'(1));
        repeat (2) tick();

        // Two-stage checker pipe, three samples
        if_b.ready = 1'b1;
        start_run(1, 3, 3, 1'b1, SEED_B);
        cyc = 1;
        while (!b_done && cyc < 5000) begin tick(); cyc++; end
        check("lat_done_cycle", VEC_W'(cyc), VEC_W'(12 * exp_att[1] + 4));
        check("lat_handshakes", VEC_W'(hs_cnt[1]), VEC_W'(3));
        check("lat_accepted", VEC_W'(b_acc), VEC_W'(3));
        repeat (2) tick();

        // Reset mid-EMIT aborts with no done pulse
        if_b.ready = 1'b0;
        start_run(1, 3, 3, 1'b0, '0);
        cyc = 1;
        while (!if_b.valid && cyc < 5000) begin tick(); cyc++; end
        check("abort_valid_pre", VEC_W'(if_b.valid), VEC_W'(1));
        cmp_en[0] = 1'b0;
        cmp_en[1] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("abort_valid", VEC_W'(if_b.valid), '0);
        check("abort_data", if_b.data, '0);
        check("abort_cand", b_cand, '0);
        check("abort_busy", VEC_W'(b_busy), '0);
        check("abort_attempts", VEC_W'(b_att), '0);
        check("abort_accepted", VEC_W'(b_acc), '0);
        d0 = 0;
        repeat (2) begin tick(); if (b_done) d0++; end
        rst_n = 1'b1;
        repeat (4) begin tick(); if (b_done) d0++; end
        check("abort_no_done", VEC_W'(d0), VEC_W'(0));
        check("abort_idle", VEC_W'(b_busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
